// File: rtl/gpio_cfg_reg_bank_pkg.sv
// rtl/gpio_cfg_reg_bank_pkg.sv - shared constants and types for the GPIO serial config bank
package gpio_cfg_reg_bank_pkg;

  localparam int DEF_GPIO_WIDTH  = 16;
  localparam int DEF_NUM_REGS    = 8;
  localparam int DEF_REG_WIDTH   = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_COMMIT_IDLE = 16;
  localparam int DEF_SDATA_BIT   = 0;
  localparam int DEF_PL_RST_BIT  = 5;

  // GPIO 5 carries soft reset, so register clocks 4..7 skip past it.
  localparam logic [DEF_NUM_REGS*8-1:0] DEF_CLK_MAP =
    {8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1};

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_SHIFT  = 2'd1,
    CFG_COMMIT = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/gpio_serial_reg.sv
// rtl/gpio_serial_reg.sv - one serial config channel: shadow shift, idle-timed commit, overflow
module gpio_serial_reg
  import gpio_cfg_reg_bank_pkg::*;
#(
  parameter int                   REG_WIDTH   = DEF_REG_WIDTH,
  parameter int                   COMMIT_IDLE = DEF_COMMIT_IDLE,
  parameter logic [REG_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 soft_rst,
  input  logic                 sdata,
  input  logic                 sclk_rise,
  output logic [REG_WIDTH-1:0] cfg_value,
  output logic                 cfg_update,
  output logic                 cfg_overflow
);

  localparam int BW = $clog2(REG_WIDTH + 2);
  localparam int IW = $clog2(COMMIT_IDLE + 1);
  localparam logic [BW-1:0] BIT_FULL  = BW'(REG_WIDTH);
  localparam logic [BW-1:0] BIT_SAT   = BW'(REG_WIDTH + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(COMMIT_IDLE - 1);

  cfg_state_t           state;
  logic [REG_WIDTH-1:0] shadow;
  logic [BW-1:0]        bit_cnt;
  logic [IW-1:0]        idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CFG_IDLE;
      shadow       <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      cfg_value    <= RESET_VAL;
      cfg_update   <= 1'b0;
      cfg_overflow <= 1'b0;
    end else if (soft_rst) begin
      state        <= CFG_IDLE;
      shadow       <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      cfg_value    <= RESET_VAL;
      cfg_update   <= 1'b0;
      cfg_overflow <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      case (state)
        CFG_IDLE: begin
          if (sclk_rise) begin
            shadow   <= {{(REG_WIDTH-1){1'b0}}, sdata};
            bit_cnt  <= BW'(1);
            idle_cnt <= '0;
            state    <= CFG_SHIFT;
          end
        end
        CFG_SHIFT: begin
          if (sclk_rise) begin
            shadow   <= {shadow[REG_WIDTH-2:0], sdata};
            idle_cnt <= '0;
            if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt >= BIT_FULL) cfg_overflow <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDLE_LAST) state <= CFG_COMMIT;
          end
        end
        CFG_COMMIT: begin
          cfg_value  <= shadow;
          cfg_update <= 1'b1;
          // An edge here opens the next frame while the current one still lands.
          if (sclk_rise) begin
            shadow   <= {{(REG_WIDTH-1){1'b0}}, sdata};
            bit_cnt  <= BW'(1);
            idle_cnt <= '0;
            state    <= CFG_SHIFT;
          end else begin
            state <= CFG_IDLE;
          end
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gpio_cfg_reg_bank.sv
// rtl/gpio_cfg_reg_bank.sv - PS GPIO serial config receiver: synchronisers, edge detect, NUM_REGS channels
module gpio_cfg_reg_bank
  import gpio_cfg_reg_bank_pkg::*;
#(
  parameter int                      GPIO_WIDTH  = DEF_GPIO_WIDTH,
  parameter int                      NUM_REGS    = DEF_NUM_REGS,
  parameter int                      REG_WIDTH   = DEF_REG_WIDTH,
  parameter int                      SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int                      COMMIT_IDLE = DEF_COMMIT_IDLE,
  parameter int                      SDATA_BIT   = DEF_SDATA_BIT,
  parameter int                      PL_RST_BIT  = DEF_PL_RST_BIT,
  parameter logic [NUM_REGS*8-1:0]   CLK_MAP     = DEF_CLK_MAP,
  parameter logic [REG_WIDTH-1:0]    RESET_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [GPIO_WIDTH-1:0]         gpio_in,
  output logic [NUM_REGS*REG_WIDTH-1:0] cfg_out,
  output logic [NUM_REGS-1:0]           cfg_update,
  output logic [NUM_REGS-1:0]           cfg_overflow,
  output logic                          soft_rst_out
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_cfg_reg_bank: SYNC_STAGES must be at least 2");
  end
  if (COMMIT_IDLE < 1) begin : g_bad_idle
    $error("gpio_cfg_reg_bank: COMMIT_IDLE must be at least 1");
  end
  if (SDATA_BIT >= GPIO_WIDTH || PL_RST_BIT >= GPIO_WIDTH) begin : g_bad_ctl
    $error("gpio_cfg_reg_bank: SDATA_BIT or PL_RST_BIT outside the GPIO bus");
  end

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] synced;
  logic [GPIO_WIDTH-1:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced       = sync_q[SYNC_STAGES-1];
  assign rise         = synced & ~prev_q;
  assign soft_rst_out = synced[PL_RST_BIT];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam int CLK_BIT = int'(CLK_MAP[i*8 +: 8]);

    if (CLK_BIT >= GPIO_WIDTH || CLK_BIT == SDATA_BIT || CLK_BIT == PL_RST_BIT) begin : g_bad_map
      $error("gpio_cfg_reg_bank: CLK_MAP entry %0d is invalid", i);
    end

    gpio_serial_reg #(
      .REG_WIDTH   (REG_WIDTH),
      .COMMIT_IDLE (COMMIT_IDLE),
      .RESET_VAL   (RESET_VAL)
    ) u_serial_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .soft_rst     (synced[PL_RST_BIT]),
      .sdata        (synced[SDATA_BIT]),
      .sclk_rise    (rise[CLK_BIT]),
      .cfg_value    (cfg_out[i*REG_WIDTH +: REG_WIDTH]),
      .cfg_update   (cfg_update[i]),
      .cfg_overflow (cfg_overflow[i])
    );
  end

endmodule
